// File: rtl/regfile_sequencer.sv
// Multicycle phase controller for a 32x32 register file: fetch, decode/read,
// execute wait, optional memory wait, write-back, one retire per instruction.
module regfile_sequencer #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        fetch_done,
  input  logic [31:0] instr,
  input  logic        mem_waitrequest,
  output logic        fetch_req,
  output logic [31:0] instr_q,
  output logic        rf_active,
  output logic        valid_read,
  output logic        valid_write,
  output logic        w_en,
  output logic        reg_dst,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_advance,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Counter only needs to hold MULDIV_CYCLES-1; keep at least one bit.
  localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CW-1:0] MULDIV_LOAD = CW'(MULDIV_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [31:0]   instr_reg, instr_next;
  logic [31:0]   retired_reg, retired_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Instruction decode from the latched word
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       dec_muldiv;
  logic       dec_wen;
  logic       dec_regdst;
  logic       dec_lw;
  logic       dec_sw;
  logic [4:0] dest_addr;
  logic       wb_wen;

  assign op    = instr_reg[31:26];
  assign funct = instr_reg[5:0];
  assign rt    = instr_reg[20:16];
  assign rd    = instr_reg[15:11];

  always_comb begin
    dec_muldiv = 1'b0;
    dec_wen    = 1'b0;
    dec_regdst = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    if (op == 6'h00) begin
      if (funct == 6'h18 || funct == 6'h19 || funct == 6'h1A || funct == 6'h1B) begin
        dec_muldiv = 1'b1;
      end else if (funct != 6'h08) begin
        dec_regdst = 1'b1;
        dec_wen    = 1'b1;
      end
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      dec_wen = 1'b1;
    end else if (op == 6'h23) begin
      dec_wen = 1'b1;
      dec_lw  = 1'b1;
    end else if (op == 6'h2B) begin
      dec_sw = 1'b1;
    end
  end

  assign dest_addr = dec_regdst ? rd : rt;
  // Writes to $0 are suppressed but the write phase itself still runs.
  assign wb_wen    = dec_wen && (dest_addr != 5'd0);

  always_comb begin
    state_next   = state_reg;
    instr_next   = instr_reg;
    retired_next = retired_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      S_HALT: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_done) begin
          instr_next = instr;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        cnt_next   = dec_muldiv ? MULDIV_LOAD : '0;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_reg == '0) begin
          state_next = (dec_lw || dec_sw) ? S_MEM : S_WB;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_MEM: begin
        if (!mem_waitrequest) state_next = S_WB;
      end
      S_WB: begin
        retired_next = retired_reg + 32'd1;
        state_next   = run ? S_FETCH : S_HALT;
      end
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_HALT;
      instr_reg   <= '0;
      retired_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      instr_reg   <= instr_next;
      retired_reg <= retired_next;
      cnt_reg     <= cnt_next;
    end
  end

  // Moore outputs decoded from state and the latched instruction
  always_comb begin
    fetch_req   = 1'b0;
    rf_active   = 1'b0;
    valid_read  = 1'b0;
    valid_write = 1'b0;
    w_en        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_advance  = 1'b0;
    reg_dst     = 1'b0;
    if (state_reg != S_HALT) reg_dst = dec_regdst;
    case (state_reg)
      S_FETCH:  fetch_req = 1'b1;
      S_DECODE: begin
        rf_active  = 1'b1;
        valid_read = 1'b1;
      end
      S_EXEC:   rf_active = 1'b1;
      S_MEM: begin
        rf_active = 1'b1;
        mem_read  = dec_lw;
        mem_write = dec_sw;
      end
      S_WB: begin
        rf_active   = 1'b1;
        valid_write = 1'b1;
        pc_advance  = 1'b1;
        w_en        = wb_wen;
      end
      default: ;
    endcase
  end

  assign instr_q = instr_reg;
  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: walks ADDU, LW, MULT, ADDIU $0,
// run drop and reset mid-MEM with hand-computed expectations.
module tb_regfile_sequencer;
  logic        clk = 1'b0;
  logic        reset, run, fetch_done, mem_waitrequest;
  logic [31:0] instr;
  logic        fetch_req, rf_active, valid_read, valid_write, w_en, reg_dst;
  logic        mem_read, mem_write, pc_advance;
  logic [31:0] instr_q, retired;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  regfile_sequencer #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .run(run), .fetch_done(fetch_done), .instr(instr),
    .mem_waitrequest(mem_waitrequest), .fetch_req(fetch_req), .instr_q(instr_q),
    .rf_active(rf_active), .valid_read(valid_read), .valid_write(valid_write),
    .w_en(w_en), .reg_dst(reg_dst), .mem_read(mem_read), .mem_write(mem_write),
    .pc_advance(pc_advance), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances until state==target or the budget runs out; returns cycles taken.
  task automatic advance_to(input logic [2:0] target, input int budget, output int cycles);
    cycles = 0;
    while (state != target && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    reset = 1'b1; run = 1'b0; fetch_done = 1'b0; instr = 32'h0; mem_waitrequest = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      outs = {fetch_req, rf_active, valid_read, valid_write, w_en, reg_dst,
              mem_read, mem_write, pc_advance, 2'b00};
      total++;
      if (state !== 3'd0 || outs !== 11'd0 || retired !== 32'd0 || instr_q !== 32'd0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: state=%0d outs=%b retired=%0d instr_q=%h, want state=0 outs=0 retired=0 instr_q=0",
                 i, state, outs, retired, instr_q);
      end
    end
    run = 1'b1;
    step();
    total++;
    if (state !== 3'd1 || fetch_req !== 1'b1) begin
      bad++;
      $display("FAIL halt_to_fetch: state=%0d fetch_req=%b, want 1/1", state, fetch_req);
    end
  endtask

  task automatic test_addu();
    instr = 32'h00221821; fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    total++;
    if (state !== 3'd2 || valid_read !== 1'b1 || rf_active !== 1'b1 || instr_q !== 32'h00221821) begin
      bad++;
      $display("FAIL addu_decode: state=%0d valid_read=%b rf_active=%b instr_q=%h, want 2/1/1/00221821",
               state, valid_read, rf_active, instr_q);
    end
    step();
    total++;
    if (state !== 3'd3 || valid_read !== 1'b0 || rf_active !== 1'b1) begin
      bad++;
      $display("FAIL addu_exec: state=%0d valid_read=%b rf_active=%b, want 3/0/1", state, valid_read, rf_active);
    end
    step();
    total++;
    if (state !== 3'd5 || w_en !== 1'b1 || reg_dst !== 1'b1 || pc_advance !== 1'b1 || valid_write !== 1'b1) begin
      bad++;
      $display("FAIL addu_wb: state=%0d w_en=%b reg_dst=%b pc_advance=%b valid_write=%b, want 5/1/1/1/1",
               state, w_en, reg_dst, pc_advance, valid_write);
    end
    step();
    total++;
    if (state !== 3'd1 || retired !== 32'd1 || pc_advance !== 1'b0) begin
      bad++;
      $display("FAIL addu_retire: state=%0d retired=%0d pc_advance=%b, want 1/1/0", state, retired, pc_advance);
    end
  endtask

  task automatic test_lw_wait();
    instr = 32'h8C250004; fetch_done = 1'b1; mem_waitrequest = 1'b1;
    step();
    fetch_done = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (state !== 3'd4 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
        bad++;
        $display("FAIL lw_mem cycle %0d: state=%0d mem_read=%b mem_write=%b, want 4/1/0", i, state, mem_read, mem_write);
      end
      if (i == 2) mem_waitrequest = 1'b0;
      step();
    end
    total++;
    if (state !== 3'd5 || w_en !== 1'b1 || reg_dst !== 1'b0 || mem_read !== 1'b0 || pc_advance !== 1'b1) begin
      bad++;
      $display("FAIL lw_wb: state=%0d w_en=%b reg_dst=%b mem_read=%b pc_advance=%b, want 5/1/0/0/1",
               state, w_en, reg_dst, mem_read, pc_advance);
    end
    step();
    total++;
    if (retired !== 32'd2) begin
      bad++;
      $display("FAIL lw_retired: retired=%0d, want 2", retired);
    end
  endtask

  task automatic test_mult();
    int n;
    instr = 32'h00220018; fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    step();
    n = 0;
    while (state == 3'd3 && n < 20) begin
      n++;
      step();
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL mult_exec_len: exec cycles=%0d, want 4", n);
    end
    total++;
    if (state !== 3'd5 || w_en !== 1'b0 || pc_advance !== 1'b1 || reg_dst !== 1'b0) begin
      bad++;
      $display("FAIL mult_wb: state=%0d w_en=%b pc_advance=%b reg_dst=%b, want 5/0/1/0", state, w_en, pc_advance, reg_dst);
    end
    step();
  endtask

  task automatic test_addiu_r0();
    int c;
    instr = 32'h24200005; fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    advance_to(3'd5, 10, c);
    total++;
    if (c !== 2 || valid_write !== 1'b1 || w_en !== 1'b0 || pc_advance !== 1'b1) begin
      bad++;
      $display("FAIL addiu_r0_wb: cycles=%0d valid_write=%b w_en=%b pc_advance=%b, want 2/1/0/1",
               c, valid_write, w_en, pc_advance);
    end
    step();
    total++;
    if (retired !== 32'd4) begin
      bad++;
      $display("FAIL addiu_r0_retired: retired=%0d, want 4", retired);
    end
  endtask

  task automatic test_run_drop();
    instr = 32'h00221821; fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
    step();
    run = 1'b0;
    step();
    total++;
    if (state !== 3'd5 || pc_advance !== 1'b1) begin
      bad++;
      $display("FAIL run_drop_wb: state=%0d pc_advance=%b, want 5/1", state, pc_advance);
    end
    step();
    total++;
    if (state !== 3'd0 || retired !== 32'd5 || fetch_req !== 1'b0 || rf_active !== 1'b0) begin
      bad++;
      $display("FAIL run_drop_halt: state=%0d retired=%0d fetch_req=%b rf_active=%b, want 0/5/0/0",
               state, retired, fetch_req, rf_active);
    end
    step();
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL run_drop_stay: state=%0d, want 0", state);
    end
  endtask

  task automatic test_reset_mid_mem();
    int c;
    run = 1'b1;
    step();
    instr = 32'h8C250004; fetch_done = 1'b1; mem_waitrequest = 1'b1;
    step();
    fetch_done = 1'b0;
    advance_to(3'd4, 10, c);
    total++;
    if (state !== 3'd4 || mem_read !== 1'b1) begin
      bad++;
      $display("FAIL rst_mem_reach: state=%0d mem_read=%b, want 4/1", state, mem_read);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; run = 1'b0; mem_waitrequest = 1'b0;
    total++;
    if (state !== 3'd0 || instr_q !== 32'd0 || retired !== 32'd0 || mem_read !== 1'b0 ||
        rf_active !== 1'b0 || reg_dst !== 1'b0) begin
      bad++;
      $display("FAIL rst_mem: state=%0d instr_q=%h retired=%0d mem_read=%b rf_active=%b reg_dst=%b, want 0/0/0/0/0/0",
               state, instr_q, retired, mem_read, rf_active, reg_dst);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_mult();
    test_addiu_r0();
    test_run_drop();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Multicycle phase controller for the 32x32 register file. Fetches one instruction word, latches it, then sequences the register-file phases: read, execute wait, optional memory wait, and write-back. It drives the register file's active, valid_read, valid_write, W_en and reg_dst controls, and signals the PC to advance once per retired instruction.

Parameters:
MULDIV_CYCLES, 4, number of EXEC cycles held for MULT/MULTU/DIV/DIVU (minimum 1)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
run  input  1  CPU enabled; sampled in HALT and WB
fetch_done  input  1  instruction word on instr is valid this cycle
instr  input  32  fetched instruction word
mem_waitrequest  input  1  data memory not ready; stalls MEM
fetch_req  output  1  request instruction fetch
instr_q  output  32  latched instruction, drives register-file Instruction input
rf_active  output  1  register-file active
valid_read  output  1  register-file read strobe
valid_write  output  1  register-file write phase
w_en  output  1  register write enable
reg_dst  output  1  1 = rd (instr_q[15:11]); 0 = rt (instr_q[20:16])
mem_read  output  1  data-memory read (LW)
mem_write  output  1  data-memory write (SW)
pc_advance  output  1  one-cycle pulse at retire
state  output  3  HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5
retired  output  32  retired-instruction count, wraps 0xFFFFFFFF -> 0

Behaviour:
- Reset (any state, mid-operation included): state=HALT, instr_q=0, retired=0, EXEC counter=0. All other outputs are 0 in the next cycle.
- Outputs are Moore outputs decoded from the state register and instr_q. They are not registered.
- HALT: all controls 0. If run=1, go to FETCH.
- FETCH: fetch_req=1. Stay while fetch_done=0. On fetch_done=1, latch instr_q<=instr and go to DECODE.
- DECODE (exactly 1 cycle): rf_active=1, valid_read=1. Load the EXEC counter with MULDIV_CYCLES-1 for muldiv, else 0. Go to EXEC.
- EXEC: rf_active=1. Decrement the counter each cycle.
  - At counter=0, go to MEM if LW/SW, else WB.
- MEM: rf_active=1. mem_read=1 for LW, mem_write=1 for SW. Stay while mem_waitrequest=1. Go to WB on the first cycle with mem_waitrequest=0.
- WB (exactly 1 cycle): rf_active=1, valid_write=1, pc_advance=1, w_en per decode, reg_dst per decode. retired increments. Next state is FETCH if run=1, else HALT.
- run deassert mid-instruction: the current instruction completes through WB, then the block halts. It never aborts.
- Decode uses op=instr_q[31:26] and funct=instr_q[5:0]:
  - op=0, funct in {0x18,0x19,0x1A,0x1B}: muldiv, w_en=0.
  - op=0, funct=0x08 (JR): w_en=0.
  - op=0, other funct: reg_dst=1, w_en=1.
  - op 0x08..0x0F (I-type ALU): reg_dst=0, w_en=1.
  - op 0x23 (LW): reg_dst=0, w_en=1, memory access.
  - op 0x2B (SW): memory access, w_en=0.
  - All other opcodes (branches, J, JAL, unknown): w_en=0, no memory access.
- Destination register 0 (selected address = 0): w_en forced 0. valid_write and pc_advance are still asserted.
- reg_dst is held valid in every non-HALT state. It is 0 when w_en would be 0.
- Minimum latency, fetch_done to pc_advance, is 3 cycles (DECODE, EXEC, WB). LW/SW add 1 + waitrequest cycles. Muldiv adds MULDIV_CYCLES-1.

Test Plan:
- Reset, then hold run=0 for 5 cycles -> state=0, all outputs 0, retired=0.
- run=1, fetch_done with instr=0x00221821 (ADDU $3,$1,$2) -> states 1,2,3,5. valid_read in DECODE. In WB: w_en=1, reg_dst=1, pc_advance=1. Then retired=1.
- instr=0x8C250004 (LW $5,4($1)), mem_waitrequest=1 for 2 cycles -> MEM held 3 cycles with mem_read=1. WB has w_en=1, reg_dst=0.
- instr=0x00220018 (MULT), MULTIPLE_CYCLES=4 -> EXEC lasts exactly 4 cycles. WB has w_en=0, pc_advance=1.
- instr=0x24200005 (ADDIU $0,$1,5) -> WB has valid_write=1, w_en=0, pc_advance=1.
- Drop run during EXEC -> instruction retires, then state=HALT. Separately, assert reset during MEM -> next cycle state=0, instr_q=0, retired=0, mem_read=0.
